// File: rtl/tracked_reg_pkg.sv
// tracked_reg_pkg
//   Shared constants and helpers for the tracked register array.
//   - DEFAULT_CNT_W : default width of the uninitialised-read counter
//   - MAX_NB        : largest byte count the byte-mask helper supports
//   - width_ok()    : legality check for the data width
//   - depth_ok()    : legality check for the entry count
//   - expand_be()   : turns a byte-enable vector into a bit mask
package tracked_reg_pkg;

   localparam int DEFAULT_CNT_W = 8;
   localparam int MAX_NB        = 32;

   // Data width must be a whole number of bytes and fit the mask helper.
   function automatic bit width_ok(input int w);
      return (w >= 8) && ((w % 8) == 0) && (w <= 8 * MAX_NB);
   endfunction

   // At least two entries so the address port is never zero bits wide.
   function automatic bit depth_ok(input int d);
      return d >= 2;
   endfunction

   // Each enable bit is replicated across its byte lane; callers truncate
   // the result to their own data width.
   function automatic logic [8*MAX_NB-1:0] expand_be(input logic [MAX_NB-1:0] be);
      logic [8*MAX_NB-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_NB; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   : clock, counts on rising edge
//     rst_n : asynchronous active-low reset, forces value to 0
//     inc   : add one this edge unless already all-ones
//     clr   : synchronous clear, wins over inc
//     value : current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value
);

   // Clear dominates increment; the count sticks once it reaches all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/tracked_reg_array.sv
// tracked_reg_array
//   Bank of DEPTH registers of WIDTH bits with byte-enable writes, a
//   one-cycle registered read port and per-byte initialisation tracking.
//   Ports:
//     clk, rst_n     : clock and asynchronous active-low reset
//     clr            : clears all init flags and the counter, keeps data
//     wr_en/wr_addr/wr_data/wr_be : byte-enabled write port
//     rd_en/rd_addr  : read request
//     rd_valid       : read response valid, one cycle after rd_en
//     rd_data        : read data (0 for an out-of-range address)
//     rd_uninit      : some byte of the read entry was never written
//     tap_bits       : bit TAP_BIT of every entry, straight from storage
//     all_init       : every byte of every entry has been written
//     uninit_rd_cnt  : saturating count of reads flagged rd_uninit
module tracked_reg_array
   import tracked_reg_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TAP_BIT = 0,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [WIDTH/8-1:0]       wr_be,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_uninit,
   output logic [DEPTH-1:0]         tap_bits,
   output logic                     all_init,
   output logic [CNT_W-1:0]         uninit_rd_cnt
);

   localparam int NB = WIDTH / 8;
   localparam int AW = $clog2(DEPTH);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("tracked_reg_array: WIDTH must be a positive multiple of 8");
   end
   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("tracked_reg_array: DEPTH must be at least 2");
   end
   if ((TAP_BIT < 0) || (TAP_BIT >= WIDTH)) begin : g_bad_tap
      $error("tracked_reg_array: TAP_BIT must lie inside WIDTH");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("tracked_reg_array: CNT_W must be at least 1");
   end

   logic [WIDTH-1:0] mem    [DEPTH];
   logic [NB-1:0]    init_q [DEPTH];
   logic             wr_in_range;
   logic             rd_in_range;
   logic [WIDTH-1:0] wr_mask;
   logic [WIDTH-1:0] rd_data_next;
   logic             rd_uninit_next;

   // Addresses past DEPTH only exist when DEPTH is not a power of two.
   assign wr_in_range = (int'(wr_addr) < DEPTH);
   assign rd_in_range = (int'(rd_addr) < DEPTH);
   assign wr_mask     = WIDTH'(expand_be(MAX_NB'(wr_be)));

   // Read lookup uses the pre-edge contents, which gives read-first
   // behaviour when reading and writing the same entry together. An
   // out-of-range read reports zero data and counts as uninitialised.
   always_comb begin
      rd_data_next   = '0;
      rd_uninit_next = 1'b1;
      if (rd_in_range) begin
         rd_data_next   = mem[rd_addr];
         rd_uninit_next = ~&init_q[rd_addr];
      end
   end

   // Storage and init flags. A write sets flags for its enabled bytes on
   // top of a simultaneous clr, so freshly written bytes stay initialised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem[e]    <= '0;
            init_q[e] <= '0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (wr_en && wr_in_range && (wr_addr == AW'(e))) begin
               mem[e]    <= (mem[e] & ~wr_mask) | (wr_data & wr_mask);
               init_q[e] <= (clr ? '0 : init_q[e]) | wr_be;
            end else if (clr) begin
               init_q[e] <= '0;
            end
         end
      end
   end

   // Read pipeline stage; data and flag hold when no read is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_uninit <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data   <= rd_data_next;
            rd_uninit <= rd_uninit_next;
         end
      end
   end

   // Counts on the same edge that registers a flagged read, so the new
   // count is visible alongside rd_valid.
   sat_counter #(
      .W (CNT_W)
   ) u_uninit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_en & rd_uninit_next),
      .clr   (clr),
      .value (uninit_rd_cnt)
   );

   // Continuous observation taps and the global initialised flag.
   always_comb begin
      tap_bits = '0;
      all_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tap_bits[i] = mem[i][TAP_BIT];
         all_init    = all_init & (&init_q[i]);
      end
   end

endmodule

// File: tb/tb_tracked_reg_array.sv
// tb_tracked_reg_array
//   Scoreboard bench: stimulus pushes hand-computed read responses into a
//   queue, a monitor pops and compares them whenever rd_valid is seen.
//   DUT configured WIDTH=16, DEPTH=5 (non power of two), CNT_W=2.
module tb_tracked_reg_array;
   import tracked_reg_pkg::*;

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        uninit;
      logic [1:0]  cnt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        rd_uninit;
   logic [4:0]  tap_bits;
   logic        all_init;
   logic [1:0]  uninit_rd_cnt;

   exp_t exp_q[$];
   int   num_checks = 0;
   int   num_fails  = 0;
   int   vec_id     = 0;

   tracked_reg_array #(
      .WIDTH   (16),
      .DEPTH   (5),
      .TAP_BIT (0),
      .CNT_W   (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr           (clr),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_be         (wr_be),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_uninit     (rd_uninit),
      .tap_bits      (tap_bits),
      .all_init      (all_init),
      .uninit_rd_cnt (uninit_rd_cnt)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison; automatic because stimulus and monitor both call it.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of stimulus; if a read is issued, queue its response.
   task automatic applyStimulus(input logic we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic [1:0] be,
                                input logic re, input logic [2:0] ra,
                                input logic c, input logic [15:0] exp_data,
                                input logic exp_uninit, input logic [1:0] exp_cnt);
      exp_t e;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      wr_be   = be;
      rd_en   = re;
      rd_addr = ra;
      clr     = c;
      if (re) begin
         vec_id++;
         e.id     = vec_id;
         e.data   = exp_data;
         e.uninit = exp_uninit;
         e.cnt    = exp_cnt;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr   = 1'b0;
   endtask

   // Monitor: compare every presented read response against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected rd_valid", 32'(rd_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("read %0d rd_data", e.id), 32'(rd_data), 32'(e.data));
               checkOutput($sformatf("read %0d rd_uninit", e.id), 32'(rd_uninit), 32'(e.uninit));
               checkOutput($sformatf("read %0d uninit_rd_cnt", e.id), 32'(uninit_rd_cnt), 32'(e.cnt));
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      rd_en   = 1'b0;
      rd_addr = '0;
      #12;
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset rd_uninit", 32'(rd_uninit), 32'd0);
      checkOutput("reset cnt", 32'(uninit_rd_cnt), 32'd0);
      checkOutput("reset tap_bits", 32'(tap_bits), 32'd0);
      checkOutput("reset all_init", 32'(all_init), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unwritten entry reads back zero, flagged, counter 1.
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd2, 0, 16'h0000, 1, 2'd1);
      checkOutput("tap after reset read", 32'(tap_bits), 32'd0);
      checkOutput("all_init after reset read", 32'(all_init), 32'd0);

      // Low byte only of entry 0.
      applyStimulus(1, 3'd0, 16'h00FF, 2'b01, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      checkOutput("tap after write0", 32'(tap_bits), 32'b00001);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd0, 0, 16'h00FF, 1, 2'd2);

      // Partial writes to entry 1 merge bytes; saturates at 3.
      applyStimulus(1, 3'd1, 16'hABCD, 2'b01, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 0, 16'h00CD, 1, 2'd3);
      checkOutput("tap after write1", 32'(tap_bits), 32'b00011);
      applyStimulus(1, 3'd1, 16'h12FF, 2'b10, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 0, 16'h12CD, 0, 2'd3);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd4, 0, 16'h0000, 1, 2'd3);

      // Out-of-range write ignored, out-of-range read zero and flagged.
      applyStimulus(1, 3'd5, 16'hFFFF, 2'b11, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 0, 16'h0000, 1, 2'd3);

      // Same-cycle write and read of entry 3 returns old data.
      applyStimulus(1, 3'd3, 16'h0011, 2'b11, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(1, 3'd3, 16'h005A, 2'b11, 1, 3'd3, 0, 16'h0011, 0, 2'd3);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 0, 16'h005A, 0, 2'd3);
      checkOutput("tap after entry3", 32'(tap_bits), 32'b00011);

      // Fill remaining bytes.
      applyStimulus(1, 3'd0, 16'h1234, 2'b11, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(1, 3'd2, 16'h0001, 2'b11, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      checkOutput("all_init before last fill", 32'(all_init), 32'd0);
      applyStimulus(1, 3'd4, 16'h8000, 2'b11, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      checkOutput("all_init filled", 32'(all_init), 32'd1);
      checkOutput("tap filled", 32'(tap_bits), 32'b00110);

      // clr drops flags and counter, keeps data.
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 1, 16'h0000, 0, 2'd0);
      checkOutput("all_init after clr", 32'(all_init), 32'd0);
      checkOutput("cnt after clr", 32'(uninit_rd_cnt), 32'd0);
      checkOutput("tap after clr", 32'(tap_bits), 32'b00110);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd0, 0, 16'h1234, 1, 2'd1);

      // clr with write: written byte stays initialised, other byte does not.
      applyStimulus(1, 3'd2, 16'h00AA, 2'b01, 0, 3'd0, 1, 16'h0000, 0, 2'd0);
      checkOutput("tap after clr+write", 32'(tap_bits), 32'b00010);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd2, 0, 16'h00AA, 1, 2'd1);

      // clr with uninit read: counter ends at 0.
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd4, 1, 16'h8000, 1, 2'd0);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd6, 0, 16'h0000, 1, 2'd1);

      // Back-to-back reads, then an idle cycle holds the last response.
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 0, 16'h12CD, 1, 2'd2);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 0, 16'h005A, 1, 2'd3);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 0, 16'h12CD, 1, 2'd3);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      checkOutput("idle rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("idle rd_data hold", 32'(rd_data), 32'h12CD);
      checkOutput("idle rd_uninit hold", 32'(rd_uninit), 32'd1);

      // Write with no byte enables is a no-op.
      applyStimulus(1, 3'd1, 16'hFFFF, 2'b00, 0, 3'd0, 0, 16'h0000, 0, 2'd0);
      applyStimulus(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 0, 16'h12CD, 1, 2'd3);

      // Bounded drain of outstanding responses.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("responses outstanding", 32'(exp_q.size()), 32'd0);

      // Reset during a read: response is dropped immediately.
      rd_en   = 1'b1;
      rd_addr = 3'd4;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      checkOutput("mid-read rd_valid before reset", 32'(rd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-read rd_valid after reset", 32'(rd_valid), 32'd0);
      checkOutput("mid-read cnt after reset", 32'(uninit_rd_cnt), 32'd0);
      checkOutput("mid-read tap after reset", 32'(tap_bits), 32'd0);
      checkOutput("mid-read all_init after reset", 32'(all_init), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
      $finish;
   end

endmodule
